// File: rtl/img_pkg.sv
// img_pkg: shared pixel/window widths and window generator FSM states
package img_pkg;
  localparam int PIX_W = 8;
  localparam int KSIZE = 3;
  localparam int WIN_W = PIX_W * KSIZE * KSIZE;
  typedef enum logic {FILL, STREAM} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: circular delay line returning the pixel written DEPTH accepted pixels ago
module line_buffer
  import img_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int W     = PIX_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  assign o_data = mem[ptr];
  always_ff @(posedge i_clk) begin
    if (i_valid) mem[ptr] <= i_data;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr <= '0;
    else if (i_valid) ptr <= ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/window_gen.sv
// window_gen: raster pixel stream to fully-populated 3x3 windows via two line delays
module window_gen
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb0, lb1;
  logic [WIN_W-1:0] win, win_n;
  state_t           state, state_n;
  logic             col_end, row_end, emit;
  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_pixel_data),
    .i_valid (i_pixel_data_valid),
    .o_data  (lb0)
  );
  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (lb0),
    .i_valid (i_pixel_data_valid),
    .o_data  (lb1)
  );
  assign col_end = col == CW'(IMG_WIDTH - 1);
  assign row_end = row == RW'(IMG_HEIGHT - 1);
  assign emit    = i_pixel_data_valid && state == STREAM && col >= CW'(2);
  assign win_n   = {i_pixel_data, win[71:64], win[63:56],
                    lb0,          win[47:40], win[39:32],
                    lb1,          win[23:16], win[15:8]};
  always_comb begin
    state_n = state;
    if (i_pixel_data_valid && col_end)
      state_n = state == FILL ? (row == RW'(1) ? STREAM : FILL) : (row_end ? FILL : STREAM);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FILL;
    else state <= state_n;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col                <= '0;
      row                <= '0;
      win                <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= emit;
      o_frame_done       <= i_pixel_data_valid && col_end && row_end;
      if (i_pixel_data_valid) begin
        win <= win_n;
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
      end
      if (emit) o_pixel_data <= win_n;
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: table-driven checks of window_gen at 4x4 and 5x3
module tb_window_gen;
  logic        clk = 1'b0;
  logic        rst, v;
  logic [7:0]  pix;
  logic [71:0] d4, d5, last4, last5;
  logic        v4, v5, f4, f5;
  int          checks = 0, errors = 0;
  typedef struct {
    logic        ev;
    logic        ef;
    logic [71:0] ed;
  } vec_t;
  vec_t tab[16];
  vec_t tab5[15];
  always #5 clk = ~clk;
  window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(v),
    .o_pixel_data(d4), .o_pixel_data_valid(v4), .o_frame_done(f4)
  );
  window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(v),
    .o_pixel_data(d5), .o_pixel_data_valid(v5), .o_frame_done(f5)
  );
  function automatic logic [71:0] w9(input int a, b, c, d, e, f, g, h, i);
    return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic logic [71:0] offs(input logic [71:0] w, input logic [7:0] o);
    logic [71:0] r;
    for (int b = 0; b < 9; b++) r[b*8+:8] = w[b*8+:8] + o;
    return r;
  endfunction
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic step(input bit sel, input logic [7:0] p, input logic val,
                      input logic ev, input logic ef, input logic [71:0] ed, input string tag);
    logic [71:0] exp_d;
    @(negedge clk);
    pix = p;
    v   = val;
    @(posedge clk);
    #1;
    if (sel) begin
      exp_d = ev ? ed : last5;
      last5 = exp_d;
      chk({tag, " valid"}, 72'(v5), 72'(ev));
      chk({tag, " data"}, d5, exp_d);
      chk({tag, " frame_done"}, 72'(f5), 72'(ef));
    end else begin
      exp_d = ev ? ed : last4;
      last4 = exp_d;
      chk({tag, " valid"}, 72'(v4), 72'(ev));
      chk({tag, " data"}, d4, exp_d);
      chk({tag, " frame_done"}, 72'(f4), 72'(ef));
    end
  endtask
  task automatic run_tab(input int off, input bit gap, input string tag);
    for (int k = 0; k < 16; k++) begin
      step(0, 8'(off + k), 1'b1, tab[k].ev, tab[k].ef, offs(tab[k].ed, 8'(off)),
           $sformatf("%s px%0d", tag, k));
      if (gap) step(0, 8'hee, 1'b0, 1'b0, 1'b0, '0, $sformatf("%s gap%0d", tag, k));
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    v   = 1'b0;
    #1;
    chk("async rst valid4", 72'(v4), 72'(0));
    chk("async rst data4", d4, 72'(0));
    @(negedge clk);
    rst   = 1'b0;
    last4 = '0;
    last5 = '0;
  endtask
  initial begin
    rst   = 1'b1;
    v     = 1'b0;
    pix   = '0;
    last4 = '0;
    last5 = '0;
    for (int k = 0; k < 16; k++) tab[k] = '{1'b0, 1'b0, 72'(0)};
    tab[10] = '{1'b1, 1'b0, w9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
    tab[11] = '{1'b1, 1'b0, w9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    tab[14] = '{1'b1, 1'b0, w9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
    tab[15] = '{1'b1, 1'b1, w9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
    for (int k = 0; k < 15; k++) tab5[k] = '{1'b0, 1'b0, 72'(0)};
    tab5[12] = '{1'b1, 1'b0, w9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    tab5[13] = '{1'b1, 1'b0, w9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    tab5[14] = '{1'b1, 1'b1, w9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pix = 8'($urandom);
      v   = 1'($urandom);
      @(posedge clk);
      #1;
      chk("reset valid4", 72'(v4), 72'(0));
      chk("reset data4", d4, 72'(0));
      chk("reset done4", 72'(f4), 72'(0));
      chk("reset valid5", 72'(v5), 72'(0));
      chk("reset data5", d5, 72'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    v   = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 8'h5a, 1'b0, 1'b0, 1'b0, '0, "idle after reset");
    run_tab(0, 1'b0, "ramp");
    run_tab(0, 1'b1, "gapped");
    run_tab(0, 1'b0, "frameA");
    run_tab(100, 1'b0, "frameB");
    for (int k = 0; k < 7; k++) step(0, 8'(200 + k), 1'b1, 1'b0, 1'b0, '0, "partial");
    pulse_reset();
    run_tab(50, 1'b0, "after reset");
    pulse_reset();
    for (int k = 0; k < 15; k++)
      step(1, 8'(k), 1'b1, tab5[k].ev, tab5[k].ef, tab5[k].ed, $sformatf("5x3 px%0d", k));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
